// File: rtl/tdm_demux4to1.sv
// Receive side of the 4:1 TDM channel path: splits a four-slot frame into four
// registered channel outputs and watches frame_sync alignment.
//
//  state | meaning
//  HUNT  | waiting for a frame_sync-qualified sample to start a frame
//  LOCK  | aligned; slot counter tracks position within the frame
module tdm_demux4to1 #(
  parameter int W = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [W-1:0]   i_din,
  input  logic           i_din_valid,
  input  logic           i_frame_sync,
  output logic [4*W-1:0] o_c,
  output logic           o_frame_valid,
  output logic           o_locked,
  output logic           o_sync_err,
  output logic [1:0]     o_slot
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t         r_state;
  logic [W-1:0]   r_shadow0;
  logic [W-1:0]   r_shadow1;
  logic [W-1:0]   r_shadow2;
  logic [4*W-1:0] r_c;
  logic           r_frame_valid;
  logic           r_sync_err;
  logic           r_locked;
  logic [1:0]     r_slot;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= HUNT;
      r_shadow0     <= '0;
      r_shadow1     <= '0;
      r_shadow2     <= '0;
      r_c           <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      r_locked      <= 1'b0;
      r_slot        <= 2'd0;
    end else begin
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      if (i_din_valid) begin
        case (r_state)
          HUNT: begin
            if (i_frame_sync) begin
              r_shadow0 <= i_din;
              r_slot    <= 2'd1;
              r_state   <= LOCK;
              r_locked  <= 1'b1;
            end
          end
          LOCK: begin
            if (i_frame_sync) begin
              // a sync anywhere but slot 0 aborts the partial frame and restarts it
              if (r_slot != 2'd0) r_sync_err <= 1'b1;
              r_shadow0 <= i_din;
              r_slot    <= 2'd1;
            end else begin
              case (r_slot)
                2'd0: begin
                  r_sync_err <= 1'b1;
                  r_state    <= HUNT;
                  r_locked   <= 1'b0;
                  r_slot     <= 2'd0;
                end
                2'd1: begin
                  r_shadow1 <= i_din;
                  r_slot    <= 2'd2;
                end
                2'd2: begin
                  r_shadow2 <= i_din;
                  r_slot    <= 2'd3;
                end
                default: begin
                  r_c           <= {i_din, r_shadow2, r_shadow1, r_shadow0};
                  r_frame_valid <= 1'b1;
                  r_slot        <= 2'd0;
                end
              endcase
            end
          end
          default: begin
            r_state  <= HUNT;
            r_locked <= 1'b0;
            r_slot   <= 2'd0;
          end
        endcase
      end
    end
  end

  assign o_c           = r_c;
  assign o_frame_valid = r_frame_valid;
  assign o_locked      = r_locked;
  assign o_sync_err    = r_sync_err;
  assign o_slot        = r_slot;

endmodule

// File: tb/tb_tdm_demux4to1.sv
// Directed bench for tdm_demux4to1: a W=1 and a W=8 instance share control inputs.
module tb_tdm_demux4to1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_valid = 1'b0;
  logic        frame_sync = 1'b0;
  logic        din1 = 1'b0;
  logic [7:0]  din8 = 8'h00;
  logic [3:0]  c1;
  logic [31:0] c8;
  logic        fv1, fv8, lk1, lk8, se1, se8;
  logic [1:0]  slot1, slot8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tdm_demux4to1 #(.W(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_din(din1), .i_din_valid(din_valid),
    .i_frame_sync(frame_sync), .o_c(c1), .o_frame_valid(fv1), .o_locked(lk1),
    .o_sync_err(se1), .o_slot(slot1)
  );

  tdm_demux4to1 #(.W(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_din(din8), .i_din_valid(din_valid),
    .i_frame_sync(frame_sync), .o_c(c8), .o_frame_valid(fv8), .o_locked(lk8),
    .o_sync_err(se8), .o_slot(slot8)
  );

  // Drive one valid sample, sample outputs 1ns after the accepting edge, then idle inputs.
  task automatic step(input logic s, input logic d, input logic [7:0] d8);
    @(negedge clk);
    din_valid = 1'b1; frame_sync = s; din1 = d; din8 = d8;
    @(posedge clk); #1;
    din_valid = 1'b0; frame_sync = 1'b0; din1 = 1'b0; din8 = 8'h00;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (c1 !== 4'b0000) begin errors++; $display("FAIL rst_c got=%b exp=0000", c1); end
    checks++; if ({lk1, fv1, se1} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {lk1, fv1, se1}); end
    checks++; if (slot1 !== 2'd0) begin errors++; $display("FAIL rst_slot got=%0d exp=0", slot1); end
    // load a frame, go mid-frame, then assert reset between edges
    step(1, 1, 0); step(0, 0, 0); step(0, 1, 0); step(0, 1, 0);
    checks++; if (c1 !== 4'b1101) begin errors++; $display("FAIL t1_pre_c got=%b exp=1101", c1); end
    step(1, 1, 0); step(0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (c1 !== 4'b0000) begin errors++; $display("FAIL t1_async_c got=%b exp=0000", c1); end
    checks++; if (lk1 !== 1'b0) begin errors++; $display("FAIL t1_async_locked got=%b exp=0", lk1); end
    checks++; if (slot1 !== 2'd0) begin errors++; $display("FAIL t1_async_slot got=%0d exp=0", slot1); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_frame();
    do_reset();
    step(1, 1, 0);
    checks++; if ({lk1, slot1} !== 3'b1_01) begin errors++; $display("FAIL t2_s0 got=%b exp=101", {lk1, slot1}); end
    step(0, 0, 0); step(0, 1, 0);
    checks++; if (fv1 !== 1'b0) begin errors++; $display("FAIL t2_early_fv got=%b exp=0", fv1); end
    step(0, 1, 0);
    checks++; if (c1 !== 4'b1101) begin errors++; $display("FAIL t2_c got=%b exp=1101", c1); end
    checks++; if ({fv1, lk1, slot1} !== 4'b1_1_00) begin errors++; $display("FAIL t2_fv_lk_slot got=%b exp=1100", {fv1, lk1, slot1}); end
    idle();
    checks++; if ({fv1, c1} !== 5'b0_1101) begin errors++; $display("FAIL t2_pulse_end got=%b exp=01101", {fv1, c1}); end
  endtask

  task automatic test_stall();
    int fv_seen = 0;
    do_reset();
    step(1, 1, 0); step(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      if (fv1) fv_seen++;
      checks++; if (slot1 !== 2'd2) begin errors++; $display("FAIL t3_stall_slot got=%0d exp=2", slot1); end
    end
    step(0, 1, 0); step(0, 1, 0);
    if (fv1) fv_seen++;
    checks++; if (c1 !== 4'b1101) begin errors++; $display("FAIL t3_c got=%b exp=1101", c1); end
    idle();
    if (fv1) fv_seen++;
    checks++; if (fv_seen !== 1) begin errors++; $display("FAIL t3_fv_count got=%0d exp=1", fv_seen); end
  endtask

  task automatic test_early_sync();
    do_reset();
    step(1, 0, 0); step(0, 1, 0); step(0, 0, 0); step(0, 1, 0);
    checks++; if (c1 !== 4'b1010) begin errors++; $display("FAIL t4_frame_a got=%b exp=1010", c1); end
    step(1, 1, 0); step(0, 1, 0);
    step(1, 0, 0);
    checks++; if ({se1, fv1} !== 2'b10) begin errors++; $display("FAIL t4_se_fv got=%b exp=10", {se1, fv1}); end
    checks++; if ({c1, lk1, slot1} !== 7'b1010_1_01) begin errors++; $display("FAIL t4_hold got=%b exp=1010101", {c1, lk1, slot1}); end
    step(0, 1, 0);
    checks++; if (se1 !== 1'b0) begin errors++; $display("FAIL t4_se_pulse got=%b exp=0", se1); end
    step(0, 1, 0); step(0, 1, 0);
    checks++; if ({c1, fv1, se1} !== 6'b1110_1_0) begin errors++; $display("FAIL t4_frame_b got=%b exp=111010", {c1, fv1, se1}); end
  endtask

  task automatic test_missed_sync();
    int fv_seen = 0;
    // continues from the aligned state left by test_early_sync (slot 0, c=1110)
    step(0, 1, 0);
    checks++; if ({se1, lk1, slot1} !== 4'b1_0_00) begin errors++; $display("FAIL t5_miss got=%b exp=1000", {se1, lk1, slot1}); end
    checks++; if (c1 !== 4'b1110) begin errors++; $display("FAIL t5_c_hold got=%b exp=1110", c1); end
    for (int i = 0; i < 5; i++) begin
      step(0, 1'(i & 1), 0);
      if (fv1 || se1) fv_seen++;
    end
    checks++; if ({fv_seen[3:0], lk1, slot1} !== 7'b0000_0_00) begin errors++; $display("FAIL t5_hunt got=%0d/%b/%0d exp=0/0/0", fv_seen, lk1, slot1); end
    step(1, 0, 0); step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    checks++; if ({c1, fv1} !== 5'b0010_1) begin errors++; $display("FAIL t5_relock got=%b exp=00101", {c1, fv1}); end
  endtask

  task automatic test_hunt_w8();
    int fv_seen = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 8'hFF);
      if (fv1 || fv8) fv_seen++;
    end
    checks++; if (fv_seen !== 0) begin errors++; $display("FAIL t6_fv got=%0d exp=0", fv_seen); end
    checks++; if ({lk1, lk8, c1} !== 6'b0) begin errors++; $display("FAIL t6_hunt got=%b exp=000000", {lk1, lk8, c1}); end
    checks++; if (c8 !== 32'h0) begin errors++; $display("FAIL t6_c8_zero got=%h exp=00000000", c8); end
    step(1, 0, 8'hA5); step(0, 0, 8'h5A); step(0, 0, 8'hFF); step(0, 0, 8'h00);
    checks++; if (c8 !== 32'h00FF5AA5) begin errors++; $display("FAIL t6_c8 got=%h exp=00ff5aa5", c8); end
    checks++; if ({fv8, lk8, slot8} !== 4'b1_1_00) begin errors++; $display("FAIL t6_w8_flags got=%b exp=1100", {fv8, lk8, slot8}); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_early_sync();
    test_missed_sync();
    test_hunt_w8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
